// File: rtl/boot_pkg.sv
// Constants and FSM encoding shared by both ends of the serial boot link.
package boot_pkg;

    localparam int unsigned WORDS  = 64;
    localparam int unsigned ADR_W  = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 7;

    typedef enum logic [2:0] {
        StIdle,
        StTxHi,
        StTxLo,
        StRxHi,
        StRxLo
    } boot_state_e;

    // Words travel high byte first.
    function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchroniser, falling-edge start detect, mid-bit sampling.
// valid_o is asserted during the stop-bit sample cycle.
module uart_byte_rx #(
    parameter int unsigned ClksPerBit = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ce_i,
    input  logic       rx_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       frame_err_o,
    output logic       idle_o
);

    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'((ClksPerBit / 2 > 0) ? ClksPerBit / 2 - 1 : 0);

    logic [1:0]      sync_q;
    logic            prev_q;
    logic            active_q;
    logic [3:0]      bit_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      shift_q;
    logic            rx_s;
    logic            sample;

    assign rx_s        = sync_q[1];
    assign sample      = active_q && (cnt_q == ((bit_q == 4'd0) ? HalfLast : CntLast));
    assign valid_o     = sample && (bit_q == 4'd9);
    assign data_o      = shift_q;
    assign frame_err_o = valid_o && !rx_s;
    assign idle_o      = !active_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            prev_q   <= 1'b1;
            active_q <= 1'b0;
            bit_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
        end else if (ce_i) begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= rx_s;
            if (!active_q) begin
                if (prev_q && !rx_s) begin
                    active_q <= 1'b1;
                    bit_q    <= '0;
                    cnt_q    <= '0;
                end
            end else if (sample) begin
                cnt_q <= '0;
                if (bit_q == 4'd0) begin
                    // A start bit that is high again at mid-bit is a glitch.
                    if (rx_s) begin
                        active_q <= 1'b0;
                    end else begin
                        bit_q <= 4'd1;
                    end
                end else if (bit_q == 4'd9) begin
                    active_q <= 1'b0;
                end else begin
                    shift_q <= {rx_s, shift_q[7:1]};
                    bit_q   <= bit_q + 4'd1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter. ready_o is also high on the last cycle of the stop bit so
// the next frame can follow with no idle gap.
module uart_byte_tx #(
    parameter int unsigned ClksPerBit = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ce_i,
    input  logic       send_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       ready_o
);

    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_q;
    logic [9:0]      frame_q;
    logic            active_q;
    logic            tx_q;
    logic            bit_end;

    assign bit_end = (cnt_q == CntLast);
    assign ready_o = !active_q || (bit_end && (bit_q == 4'd9));
    assign tx_o    = tx_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '1;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
        end else if (ce_i) begin
            if (send_i && ready_o) begin
                frame_q  <= {1'b1, data_i, 1'b0};
                tx_q     <= 1'b0;
                bit_q    <= '0;
                cnt_q    <= '0;
                active_q <= 1'b1;
            end else if (active_q) begin
                if (bit_end) begin
                    cnt_q <= '0;
                    if (bit_q == 4'd9) begin
                        active_q <= 1'b0;
                        tx_q     <= 1'b1;
                    end else begin
                        bit_q   <= bit_q + 4'd1;
                        tx_q    <= frame_q[1];
                        frame_q <= {1'b1, frame_q[9:1]};
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/boot_host.sv
// Host end of the boot link: streams a 64x16 image out over UART, then receives the
// CPU's memory dump and counts words that differ from the image.
module boot_host
    import boot_pkg::*;
#(
    parameter int unsigned ClksPerBit    = 868,
    parameter int unsigned RxTimeoutBits = 40
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ce_i,
    input  logic              img_we_i,
    input  logic [ADR_W-1:0]  img_adr_i,
    input  logic [DATA_W-1:0] img_data_i,
    input  logic              start_i,
    input  logic              check_i,
    input  logic              rx_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [CNT_W-1:0]  err_count_o
);

    localparam int unsigned TimeoutCycles = RxTimeoutBits * ClksPerBit;
    localparam int unsigned TmrW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TmrW-1:0]  TmrLast  = TmrW'(TimeoutCycles - 1);
    localparam logic [ADR_W-1:0] LastAdr  = ADR_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] WordsCnt = CNT_W'(WORDS);

    logic [DATA_W-1:0] img_q [WORDS];

    boot_state_e      state_q;
    logic [ADR_W-1:0] adr_q;
    logic [ADR_W-1:0] adr_nxt;
    logic [7:0]       hi_q;
    logic             word_bad_q;
    logic [TmrW-1:0]  timer_q;
    logic             done_q;
    logic             error_q;
    logic [CNT_W-1:0] err_count_q;

    logic       tx_send;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_idle;

    assign adr_nxt     = adr_q + 1'b1;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_count_o = err_count_q;

    always_ff @(posedge clk_i) begin
        if (ce_i && img_we_i && (state_q == StIdle)) begin
            img_q[img_adr_i] <= img_data_i;
        end
    end

    // The next byte is offered combinationally so a frame can start on the same edge
    // that accepts start_i or finishes the previous stop bit.
    always_comb begin
        tx_send = 1'b0;
        tx_data = '0;
        unique case (state_q)
            StIdle: begin
                tx_send = start_i;
                tx_data = word_byte(img_q[0], 1'b1);
            end
            StTxHi: begin
                tx_send = tx_ready;
                tx_data = word_byte(img_q[adr_q], 1'b0);
            end
            StTxLo: begin
                tx_send = tx_ready && (adr_q != LastAdr);
                tx_data = word_byte(img_q[adr_nxt], 1'b1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            adr_q       <= '0;
            hi_q        <= '0;
            word_bad_q  <= 1'b0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else if (ce_i) begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StTxHi;
                        adr_q   <= '0;
                    end else if (check_i) begin
                        state_q     <= StRxHi;
                        adr_q       <= '0;
                        error_q     <= 1'b0;
                        err_count_q <= '0;
                        word_bad_q  <= 1'b0;
                        timer_q     <= '0;
                    end
                end
                StTxHi: begin
                    if (tx_ready) begin
                        state_q <= StTxLo;
                    end
                end
                StTxLo: begin
                    if (tx_ready) begin
                        if (adr_q == LastAdr) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            adr_q   <= adr_nxt;
                            state_q <= StTxHi;
                        end
                    end
                end
                StRxHi, StRxLo: begin
                    if (rx_valid) begin
                        timer_q <= '0;
                        if (rx_frame_err) begin
                            error_q <= 1'b1;
                        end
                        if (state_q == StRxHi) begin
                            hi_q       <= rx_data;
                            word_bad_q <= rx_frame_err;
                            state_q    <= StRxLo;
                        end else begin
                            // A framing error on either byte counts once for the word.
                            if (word_bad_q || rx_frame_err || ({hi_q, rx_data} != img_q[adr_q])) begin
                                err_count_q <= err_count_q + 7'd1;
                                error_q     <= 1'b1;
                            end
                            word_bad_q <= 1'b0;
                            if (adr_q == LastAdr) begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end else begin
                                adr_q   <= adr_nxt;
                                state_q <= StRxHi;
                            end
                        end
                    end else if (!rx_idle) begin
                        timer_q <= '0;
                    end else if (timer_q == TmrLast) begin
                        // Every word not yet verified is reported as bad.
                        error_q     <= 1'b1;
                        err_count_q <= WordsCnt - {1'b0, adr_q};
                        done_q      <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    uart_byte_tx #(
        .ClksPerBit(ClksPerBit)
    ) u_tx (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ce_i   (ce_i),
        .send_i (tx_send),
        .data_i (tx_data),
        .tx_o   (tx_o),
        .ready_o(tx_ready)
    );

    uart_byte_rx #(
        .ClksPerBit(ClksPerBit)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ce_i       (ce_i),
        .rx_i       (rx_i),
        .valid_o    (rx_valid),
        .data_o     (rx_data),
        .frame_err_o(rx_frame_err),
        .idle_o     (rx_idle)
    );

endmodule

// File: tb/tb_boot_host.sv
// Directed bench for boot_host: upload waveform model, dump replay, mismatch, framing,
// timeout, start/check priority, ce freeze and mid-frame reset.
module tb_boot_host;
    import boot_pkg::*;

    localparam int unsigned Cpb      = 4;
    localparam int unsigned ToBits   = 40;
    localparam int          UpCycles = 1280 * Cpb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        img_we = 1'b0;
    logic [5:0]  img_adr = '0;
    logic [15:0] img_data = '0;
    logic        start = 1'b0;
    logic        check = 1'b0;
    logic        rx = 1'b1;
    logic        tx, busy, done, error;
    logic [6:0]  err_count;

    boot_host #(
        .ClksPerBit   (Cpb),
        .RxTimeoutBits(ToBits)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ce_i       (ce),
        .img_we_i   (img_we),
        .img_adr_i  (img_adr),
        .img_data_i (img_data),
        .start_i    (start),
        .check_i    (check),
        .rx_i       (rx),
        .tx_o       (tx),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    int          vecs = 0;
    int          miss = 0;
    logic [15:0] img_m  [64];
    logic [15:0] dump_m [64];
    logic [7:0]  cap [$];
    logic [7:0]  dec_b;
    bit          up_on = 1'b0;
    int          up_t = 0;
    bit          cap_en = 1'b0;
    int          done_cnt = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // {tx, busy, done} expected t ce-cycles after start was accepted.
    function automatic logic [2:0] up_expect(input int t);
        int f;
        int b;
        logic [7:0] by;
        if (t >= UpCycles) return 3'b101;
        f  = t / (10 * Cpb);
        b  = (t % (10 * Cpb)) / Cpb;
        by = f[0] ? img_m[f / 2][7:0] : img_m[f / 2][15:8];
        if (b == 0) return 3'b010;
        if (b == 9) return 3'b110;
        return {by[b - 1], 2'b10};
    endfunction

    always @(negedge clk) begin
        if (up_on) begin
            cmp($sformatf("upload t=%0d {tx,busy,done}", up_t), {29'd0, tx, busy, done},
                {29'd0, up_expect(up_t)});
            if (up_t >= UpCycles) up_on = 1'b0;
            else if (ce) up_t++;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // Independent UART decoder on tx.
    always begin
        @(negedge clk);
        if (cap_en && tx === 1'b0) begin
            repeat (Cpb / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (Cpb) @(negedge clk);
                dec_b[i] = tx;
            end
            repeat (Cpb) @(negedge clk);
            cap.push_back(dec_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch_upload(input bit with_check);
        start = 1'b1;
        check = with_check;
        tick();
        start = 1'b0;
        check = 1'b0;
        up_t  = 0;
        up_on = 1'b1;
    endtask

    task automatic wait_upload();
        for (int i = 0; i < UpCycles + 200 && up_on; i++) tick();
        cmp("upload finished in time", {31'd0, up_on}, 32'd0);
        up_on = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        logic [9:0] fr;
        fr = {~bad_stop, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = (i < 10) ? fr[i] : 1'b1;
            repeat (Cpb) tick();
        end
    endtask

    task automatic run_check(input int bad_byte, input string tag);
        int d0;
        int exp_e;
        check = 1'b1;
        tick();
        check = 1'b0;
        d0 = done_cnt;
        for (int w = 0; w < 64; w++) begin
            send_byte(dump_m[w][15:8], bad_byte == 2 * w);
            send_byte(dump_m[w][7:0], bad_byte == 2 * w + 1);
        end
        for (int i = 0; i < 50 && done_cnt == d0; i++) tick();
        exp_e = 0;
        for (int w = 0; w < 64; w++) begin
            if (dump_m[w] != img_m[w] || (bad_byte >= 0 && bad_byte / 2 == w)) exp_e++;
        end
        cmp({tag, " done pulses"}, done_cnt - d0, 1);
        cmp({tag, " err_count"}, {25'd0, err_count}, exp_e);
        cmp({tag, " error"}, {31'd0, error}, {31'd0, exp_e != 0});
        cmp({tag, " busy"}, {31'd0, busy}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low;
        for (int k = 0; k < 64; k++) img_m[k] = 16'hA500 + 16'(k);

        repeat (3) tick();
        cmp("reset tx", {31'd0, tx}, 1);
        cmp("reset busy", {31'd0, busy}, 0);
        cmp("reset done", {31'd0, done}, 0);
        cmp("reset error", {31'd0, error}, 0);
        cmp("reset err_count", {25'd0, err_count}, 0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 64; k++) begin
            img_we   = 1'b1;
            img_adr  = 6'(k);
            img_data = img_m[k];
            tick();
        end
        img_we = 1'b0;

        // Upload; a write attempted while busy must not reach the image.
        cap_en = 1'b1;
        launch_upload(1'b0);
        repeat (100) tick();
        img_we   = 1'b1;
        img_adr  = 6'd63;
        img_data = 16'h0000;
        tick();
        img_we = 1'b0;
        wait_upload();
        cap_en = 1'b0;
        cmp("captured frames", cap.size(), 128);
        cmp("byte 0", {24'd0, cap[0]}, 32'hA5);
        cmp("byte 1", {24'd0, cap[1]}, 32'h00);
        cmp("byte 126", {24'd0, cap[126]}, 32'hA5);
        cmp("byte 127", {24'd0, cap[127]}, 32'h3F);

        for (int w = 0; w < 64; w++) dump_m[w] = {cap[2 * w], cap[2 * w + 1]};
        run_check(-1, "loopback");
        cmp("loopback err_count literal", {25'd0, err_count}, 0);

        for (int w = 0; w < 64; w++) dump_m[w] = img_m[w];
        dump_m[5]  = 16'h0000;
        dump_m[63] = 16'h0000;
        run_check(-1, "mismatch");
        cmp("mismatch err_count literal", {25'd0, err_count}, 2);
        cmp("mismatch error literal", {31'd0, error}, 1);

        for (int w = 0; w < 64; w++) dump_m[w] = img_m[w];
        run_check(10, "framing");
        cmp("framing err_count literal", {25'd0, err_count}, 1);

        // Timeout with rx idle.
        rx    = 1'b1;
        check = 1'b1;
        tick();
        check = 1'b0;
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        cmp("timeout latency", n, ToBits * Cpb);
        cmp("timeout error", {31'd0, error}, 1);
        cmp("timeout err_count", {25'd0, err_count}, 64);
        tick();
        cmp("timeout busy", {31'd0, busy}, 0);

        // start wins over check; ce low mid-upload freezes everything.
        launch_upload(1'b1);
        repeat (1000) tick();
        ce = 1'b0;
        repeat (23) tick();
        ce = 1'b1;
        wait_upload();
        cmp("priority keeps error", {31'd0, error}, 1);
        cmp("priority keeps err_count", {25'd0, err_count}, 64);

        // Reset in the middle of a frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        cmp("tx low before reset", {31'd0, tx}, 0);
        rst_n = 1'b0;
        tick();
        cmp("mid reset tx", {31'd0, tx}, 1);
        cmp("mid reset busy", {31'd0, busy}, 0);
        cmp("mid reset done", {31'd0, done}, 0);
        cmp("mid reset error", {31'd0, error}, 0);
        cmp("mid reset err_count", {25'd0, err_count}, 0);
        rst_n = 1'b1;
        low = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) low++;
        end
        cmp("idle after reset", low, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/boot_host.md
# boot_host

Host-side end of the serial boot link used by `CPU_Bootloader`. It holds a 64×16 program image, streams it out over UART to the CPU's boot loader, then captures the memory dump the CPU returns when `scan_memory` is asserted and compares it word by word against the image. It lives in the FPGA test harness, or as a second-board loader, with `tx` wired to the CPU's `rx` and `rx` wired to the CPU's `tx`.

## Interface
- `CLKS_PER_BIT`, default 868: clock-enabled cycles per UART bit (100 MHz / 115200).
- `RX_TIMEOUT_BITS`, default 40: idle bit-times tolerated while waiting for a dump byte.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-low.
- `ce`  in  1  clock enable; all state advances only when `ce`=1. Reset does not depend on `ce`.
- `img_we`  in  1  image buffer write strobe; honoured only in IDLE.
- `img_adr`  in  6  image buffer address.
- `img_data`  in  16  image buffer write data.
- `start`  in  1  one-cycle pulse: upload the image.
- `check`  in  1  one-cycle pulse: receive and verify the 64-word dump.
- `rx`  in  1  serial input from the CPU `tx`.
- `tx`  out  1  serial output to the CPU `rx`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when an upload or check completes.
- `error`  out  1  sticky flag: framing error, timeout, or mismatch in the last check.
- `err_count`  out  7  number of mismatched words in the last check, 0–64.

## Operation
- UART frame format: 8N1. Start bit 0, data bits LSB first, one stop bit 1, each bit lasting `CLKS_PER_BIT` ce-cycles. `tx` idles high.
- Word encoding: two bytes per word, high byte first. A transfer is 64 words, addresses 0 to 63, which is 128 bytes.
- FSM states:
  - IDLE. `start` goes to TX_HI with address 0. `check` goes to RX_HI with address 0 and clears `error` and `err_count`. If both are asserted in the same cycle, `start` wins and `check` is dropped.
  - TX_HI: send `img[adr][15:8]`, then go to TX_LO.
  - TX_LO: send `img[adr][7:0]`. Then go to TX_HI with `adr+1`, or, if `adr` is 63, go to IDLE and pulse `done`.
  - RX_HI: receive a byte into `hi`, then go to RX_LO.
  - RX_LO: receive a byte and compare `{hi,byte}` with `img[adr]`. On mismatch, increment `err_count` and set `error`. Then go to RX_HI with `adr+1`, or, if `adr` is 63, go to IDLE and pulse `done`.
- Receiver behaviour:
  - Detects the falling edge of a 2-FF synchronised `rx`.
  - Samples each bit at mid-bit, i.e. `CLKS_PER_BIT/2` after the edge, then every `CLKS_PER_BIT`.
  - A stop bit of 0 sets `error` and counts as a mismatch for that word. Reception continues.
  - No start bit within `RX_TIMEOUT_BITS` bit-times sets `error`, forces `err_count` to `64 − words_verified`, pulses `done`, and returns to IDLE.
- `start` and `check` are ignored while `busy`. `img_we` is ignored while `busy`.
- `err_count` cannot exceed 64, so no wrap occurs. The 6-bit address wraps naturally, and the terminal test is done on 63 before the increment.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `error`=0, `err_count`=0, state IDLE, address 0. The image buffer is not reset.
- Reset mid-transfer: `tx` is high on the cycle after the reset edge, and a partial frame is abandoned.
- Start latency: the `tx` start bit begins on the first ce-cycle after `start` is sampled. `busy` rises on that same edge.
- Bytes are sent back to back with no inter-frame gap. A full upload is 1280·`CLKS_PER_BIT` ce-cycles, and `done` pulses in the ce-cycle after the final stop bit ends.
- During a check, `done` pulses in the cycle after the last stop-bit sample.
- `img_we` write is synchronous. A write takes effect at the next edge, and a read in the same cycle returns the old data.

## Structure
- Shared package `boot_pkg`: `WORDS`=64, `ADR_W`=6, `DATA_W`=16, and the FSM state encoding. The CPU-side loader uses the same package.
- Sub-modules:
  - `uart_byte_tx`, natural and reusable: inputs `send` and `data[7:0]`; outputs `tx` and `ready`.
  - `uart_byte_rx`: outputs `valid`, `data`, `frame_err`.
- The image buffer is an inferred 64×16 register array inside `boot_host`.

## Test plan
- Upload: with `CLKS_PER_BIT`=4, load `img[k]=16'hA500+k` and pulse `start`. Expect 128 frames on `tx`, the first bytes being 0xA5 then 0x00 and the last being 0xA5 then 0x3F. `done` pulses once after 5120 ce-cycles.
- Loopback check: connect `tx` to `rx`, pulse `start`, then `check` once the transfer ends. Expect `err_count`=0 and `error`=0.
- Mismatch: a bench UART returns the image with words 5 and 63 changed to 16'h0000. Expect `err_count`=2 and `error`=1.
- Framing error: force the stop bit of byte 10 to 0. Expect `error`=1, `err_count`=1, and the check still completes with `done`.
- Timeout: pulse `check` with `rx` held at 1. After 40 bit-times expect `error`=1, `err_count`=64, a `done` pulse, and `busy`=0.
- Priority and reset: assert `start` and `check` together, and confirm an upload occurs. Pull `rst` low mid-frame, and confirm `tx`=1 on the next cycle and all outputs at their reset values. Hold `ce`=0 and confirm the FSM and `tx` are frozen.
